fp_fcvt_s_w: RTL and testbench
==============================

Name: fp_fcvt_s_w

Overview:
- Multi-cycle converter from a 32-bit signed or unsigned integer to an IEEE-754 binary32 value (RISC-V fcvt.s.w / fcvt.s.wu).
- Produces FP operands in the format the FP comparators and ALU consume, i.e. the opposite direction of the FP→boolean/integer path.
- Sits beside the comparators inside fp_alu.
- Uses a valid/ready handshake on input and output, so the ALU can stall on a busy unit.

Parameters:
- None. Widths are fixed: 32-bit integer source, binary32 result.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand valid
- in_ready  output  1  converter can accept an operand
- int_in  input  32  integer operand
- is_signed  input  1  1: two's-complement source (fcvt.s.w); 0: unsigned (fcvt.s.wu)
- rm  input  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101–111 treated as RNE
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- fp_out  output  32  binary32 result
- nx  output  1  inexact flag; 1 when any nonzero bit was discarded by rounding

Behaviour:
- States: IDLE, NORM, ROUND, DONE.
- Reset (async, any state): state=IDLE; in_ready=1; out_valid=0; fp_out=0; nx=0; internal regs cleared. An in-flight operation is discarded with no output.
- in_ready = (state==IDLE). out_valid = (state==DONE).
- Accept edge k (in_valid & in_ready):
  - capture sign = is_signed & int_in[31];
  - capture mag = sign ? -int_in : int_in, as 32-bit unsigned, so 0x80000000 gives mag 0x80000000;
  - capture rm, zero flag (mag==0), lz=0;
  - state → NORM, step counter=0.
- NORM, edges k+1..k+5: binary-search normalization with shift amounts 16, 8, 4, 2, 1 in that order.
  - If the top S bits of mag are all zero: mag <<= S, lz += S.
  - After the 5th step, mag[31]=1 unless zero. State → ROUND.
- ROUND, edge k+6:
  - mantissa = mag[30:8]; guard = mag[7]; sticky = |mag[6:0].
  - Increment decision:
    - RNE: guard & (sticky | mantissa[0])
    - RTZ: 0
    - RDN: sign & (guard|sticky)
    - RUP: ~sign & (guard|sticky)
    - RMM: guard
  - exp = 127 + 31 − lz.
  - If mantissa+inc carries out of 23 bits: mantissa=0, exp+1.
  - fp_out = {sign, exp[7:0], mantissa}; nx = guard|sticky.
  - Zero input: fp_out=0x00000000 (+0.0, never −0.0), nx=0.
  - State → DONE.
- Latency: fixed 6 cycles from accept edge to out_valid high, independent of value.
- DONE: fp_out and nx held stable while out_valid=1 & out_ready=0.
  - On out_valid & out_ready at an edge: state → IDLE, out_valid=0.
  - fp_out/nx keep their last value.
  - in_ready rises the following cycle; there is no same-cycle accept while draining.
- in_valid asserted while in_ready=0 is ignored. Input need not be held after the accept edge.
- Overflow, NaN and infinity cannot occur: the maximum result is 2^32 = 0x4F800000.
- Input changes during NORM/ROUND/DONE have no effect.

Decomposition:
- fp_pkg holds:
  - rounding-mode enum (RM_RNE..RM_RMM);
  - constants FP_BIAS=127, FP_EXP_W=8, FP_MAN_W=23;
  - converter state enum (CVT_IDLE, CVT_NORM, CVT_ROUND, CVT_DONE).
- One combinational sub-module, fp_round_inc:
  - inputs sign, lsb, guard, sticky, rm;
  - output inc;
  - reused later by other FP result paths.
- Leading-zero search stays in the FSM datapath.

Test Plan:
- int_in=0x00000001, is_signed=1, rm=RNE → fp_out=0x3F800000, nx=0, out_valid exactly 6 cycles after accept.
- int_in=0xFFFFFFFF: is_signed=1 → 0xBF800000 (−1.0); is_signed=0, rm=RNE → 0x4F800000, nx=1; is_signed=0, rm=RTZ → 0x4F7FFFFF, nx=1.
- int_in=0x80000000, is_signed=1 → 0xCF000000, nx=0. int_in=0 → 0x00000000, nx=0.
- int_in=0x01000001 (16777217), unsigned: RNE → 0x4B800000, RUP → 0x4B800001, RDN → 0x4B800000, all nx=1. Signed 0xFEFFFFFF (−16777217) with RDN → 0xCB800001.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → fp_out stable, in_ready=0, a new in_valid is ignored. Release → in_ready=1 the cycle after the drain edge. Back-to-back operands are each converted correctly.
- Assert rst_n=0 during NORM → out_valid=0, in_ready=1 immediately (async). After release, a new operand 0x00000064 (100) → 0x42C80000.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared floating-point definitions: rounding modes, binary32 field sizes
// and the integer-to-float converter state encoding.
package fp_pkg;

   typedef enum logic [2:0] {
      RM_RNE = 3'b000,
      RM_RTZ = 3'b001,
      RM_RDN = 3'b010,
      RM_RUP = 3'b011,
      RM_RMM = 3'b100
   } rm_e;

   localparam int FP_BIAS  = 127;
   localparam int FP_EXP_W = 8;
   localparam int FP_MAN_W = 23;

   typedef enum logic [1:0] {
      CVT_IDLE  = 2'd0,
      CVT_NORM  = 2'd1,
      CVT_ROUND = 2'd2,
      CVT_DONE  = 2'd3
   } cvt_state_e;

endpackage

// File: rtl/fp_round_inc.sv
// Rounding increment decision for a truncated magnitude, shared by the FP
// result paths. Reserved rounding modes (101-111) behave as RNE.
module fp_round_inc
   import fp_pkg::*;
(
   input  logic       sign,
   input  logic       lsb,
   input  logic       guard,
   input  logic       sticky,
   input  logic [2:0] rm,
   output logic       inc
);

   function automatic logic round_inc(input logic s, input logic l, input logic g,
                                      input logic st, input logic [2:0] mode);
      logic r;
      case (mode)
         RM_RTZ:  r = 1'b0;
         RM_RDN:  r = s & (g | st);
         RM_RUP:  r = ~s & (g | st);
         RM_RMM:  r = g;
         default: r = g & (st | l);
      endcase
      return r;
   endfunction

   // Pure combinational decision from the discarded bits and the mode.
   always_comb begin
      inc = round_inc(sign, lsb, guard, sticky, rm);
   end

endmodule

// File: rtl/fp_fcvt_s_w.sv
// Multi-cycle 32-bit integer to binary32 converter (fcvt.s.w / fcvt.s.wu).
// Accept, five binary-search normalization steps, one rounding step, then
// hold the result until the consumer takes it: fixed 6-cycle latency.
module fp_fcvt_s_w
   import fp_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] int_in,
   input  logic        is_signed,
   input  logic [2:0]  rm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] fp_out,
   output logic        nx
);

   cvt_state_e  state;
   logic        sign_r;
   logic [31:0] mag_r;
   logic [2:0]  rm_r;
   logic        zero_r;
   logic [4:0]  lz_r;
   logic [2:0]  step_r;

   logic signed [31:0] int_s;
   logic [31:0]        mag_in;
   logic               sign_in;

   logic [4:0]  amt;
   logic        top_zero;

   logic [FP_MAN_W-1:0] mant;
   logic                guard;
   logic                sticky;
   logic                inc;
   logic [FP_MAN_W:0]   mant_sum;
   logic [FP_EXP_W-1:0] exp_base;
   logic [FP_EXP_W-1:0] exp_fin;
   logic [31:0]         result;

   assign in_ready  = (state == CVT_IDLE);
   assign out_valid = (state == CVT_DONE);

   // Operand capture: sign-magnitude split; 0x80000000 negates to itself.
   always_comb begin
      int_s   = signed'(int_in);
      sign_in = is_signed & int_in[31];
      mag_in  = sign_in ? 32'(-int_s) : int_in;
   end

   // One normalization step: shift by 16,8,4,2,1 when the top bits are clear.
   always_comb begin
      amt      = 5'd0;
      top_zero = 1'b0;
      case (step_r)
         3'd0:    begin amt = 5'd16; top_zero = (mag_r[31:16] == 16'd0); end
         3'd1:    begin amt = 5'd8;  top_zero = (mag_r[31:24] == 8'd0);  end
         3'd2:    begin amt = 5'd4;  top_zero = (mag_r[31:28] == 4'd0);  end
         3'd3:    begin amt = 5'd2;  top_zero = (mag_r[31:30] == 2'd0);  end
         default: begin amt = 5'd1;  top_zero = ~mag_r[31];              end
      endcase
   end

   fp_round_inc u_round_inc (
      .sign   (sign_r),
      .lsb    (mant[0]),
      .guard  (guard),
      .sticky (sticky),
      .rm     (rm_r),
      .inc    (inc)
   );

   // Rounding and packing of the normalized magnitude.
   always_comb begin
      mant     = mag_r[30:8];
      guard    = mag_r[7];
      sticky   = |mag_r[6:0];
      mant_sum = {1'b0, mant} + {{FP_MAN_W{1'b0}}, inc};
      exp_base = FP_EXP_W'(FP_BIAS + 31) - {3'b000, lz_r};
      exp_fin  = exp_base + {{(FP_EXP_W-1){1'b0}}, mant_sum[FP_MAN_W]};
      result   = {sign_r, exp_fin, mant_sum[FP_MAN_W-1:0]};
   end

   // Converter FSM and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= CVT_IDLE;
         sign_r <= 1'b0;
         mag_r  <= 32'd0;
         rm_r   <= 3'd0;
         zero_r <= 1'b0;
         lz_r   <= 5'd0;
         step_r <= 3'd0;
         fp_out <= 32'd0;
         nx     <= 1'b0;
      end else begin
         case (state)
            CVT_IDLE: begin
               if (in_valid) begin
                  sign_r <= sign_in;
                  mag_r  <= mag_in;
                  rm_r   <= rm;
                  zero_r <= (mag_in == 32'd0);
                  lz_r   <= 5'd0;
                  step_r <= 3'd0;
                  state  <= CVT_NORM;
               end
            end
            CVT_NORM: begin
               if (top_zero) begin
                  mag_r <= mag_r << amt;
                  lz_r  <= lz_r + amt;
               end
               step_r <= step_r + 3'd1;
               if (step_r == 3'd4) begin
                  state <= CVT_ROUND;
               end
            end
            CVT_ROUND: begin
               if (zero_r) begin
                  fp_out <= 32'd0;
                  nx     <= 1'b0;
               end else begin
                  fp_out <= result;
                  nx     <= guard | sticky;
               end
               state <= CVT_DONE;
            end
            default: begin
               if (out_ready) begin
                  state <= CVT_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fp_fcvt_s_w.sv
// Directed table-driven bench for the integer to binary32 converter, plus
// backpressure and mid-operation reset sequences.
module tb_fp_fcvt_s_w;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] int_in;
   logic        is_signed;
   logic [2:0]  rm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] fp_out;
   logic        nx;

   int tests;
   int fails;

   fp_fcvt_s_w dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .int_in    (int_in),
      .is_signed (is_signed),
      .rm        (rm),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .fp_out    (fp_out),
      .nx        (nx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic        sgn;
      logic [2:0]  mode;
      logic [31:0] exp_fp;
      logic        exp_nx;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
      end
   endtask

   // Accept one operand, measure latency, drain the result.
   task automatic run_op(input logic [31:0] a, input logic sgn, input logic [2:0] mode,
                         output logic [31:0] res, output logic res_nx, output int lat);
      int wait_cnt;
      wait_cnt = 0;
      @(negedge clk);
      while (!in_ready && wait_cnt < 50) begin
         @(negedge clk);
         wait_cnt++;
      end
      chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
      int_in    = a;
      is_signed = sgn;
      rm        = mode;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      int_in    = 32'hDEADBEEF;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      res    = fp_out;
      res_nx = nx;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("out_valid_after_drain", {31'd0, out_valid}, 32'd0);
      chk("in_ready_after_drain", {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      logic [31:0] res;
      logic        rnx;
      int          lat;

      tests = 0;
      fails = 0;

      vecs[0]  = '{32'h00000001, 1'b1, 3'b000, 32'h3F800000, 1'b0};
      vecs[1]  = '{32'hFFFFFFFF, 1'b1, 3'b000, 32'hBF800000, 1'b0};
      vecs[2]  = '{32'hFFFFFFFF, 1'b0, 3'b000, 32'h4F800000, 1'b1};
      vecs[3]  = '{32'hFFFFFFFF, 1'b0, 3'b001, 32'h4F7FFFFF, 1'b1};
      vecs[4]  = '{32'h80000000, 1'b1, 3'b000, 32'hCF000000, 1'b0};
      vecs[5]  = '{32'h00000000, 1'b1, 3'b000, 32'h00000000, 1'b0};
      vecs[6]  = '{32'h01000001, 1'b0, 3'b000, 32'h4B800000, 1'b1};
      vecs[7]  = '{32'h01000001, 1'b0, 3'b011, 32'h4B800001, 1'b1};
      vecs[8]  = '{32'h01000001, 1'b0, 3'b010, 32'h4B800000, 1'b1};
      vecs[9]  = '{32'hFEFFFFFF, 1'b1, 3'b010, 32'hCB800001, 1'b1};
      vecs[10] = '{32'hFEFFFFFF, 1'b1, 3'b011, 32'hCB800000, 1'b1};
      vecs[11] = '{32'h01000001, 1'b0, 3'b100, 32'h4B800001, 1'b1};
      vecs[12] = '{32'h01000003, 1'b0, 3'b111, 32'h4B800002, 1'b1};
      vecs[13] = '{32'h80000000, 1'b0, 3'b000, 32'h4F000000, 1'b0};
      vecs[14] = '{32'h00000064, 1'b1, 3'b000, 32'h42C80000, 1'b0};
      vecs[15] = '{32'h00000007, 1'b1, 3'b001, 32'h40E00000, 1'b0};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      int_in    = 32'd0;
      is_signed = 1'b0;
      rm        = 3'd0;
      out_ready = 1'b0;
      #1;
      chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
      chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset_fp_out", fp_out, 32'd0);
      chk("reset_nx", {31'd0, nx}, 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 16; i++) begin
         run_op(vecs[i].a, vecs[i].sgn, vecs[i].mode, res, rnx, lat);
         chk($sformatf("vec%0d_fp", i), res, vecs[i].exp_fp);
         chk($sformatf("vec%0d_nx", i), {31'd0, rnx}, {31'd0, vecs[i].exp_nx});
         chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd6);
      end

      // Backpressure: result held, new operand ignored while DONE.
      begin
         int wait_cnt;
         @(negedge clk);
         int_in = 32'h00000064; is_signed = 1'b1; rm = 3'b000; in_valid = 1'b1;
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         wait_cnt = 0;
         while (!out_valid && wait_cnt < 20) begin
            @(posedge clk);
            #1;
            wait_cnt++;
         end
         chk("bp_latency", 32'(wait_cnt), 32'd6);
         int_in = 32'h00000005; in_valid = 1'b1;
         for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            chk("bp_fp_stable", fp_out, 32'h42C80000);
            chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
            chk("bp_out_valid_held", {31'd0, out_valid}, 32'd1);
         end
         in_valid  = 1'b0;
         out_ready = 1'b1;
         @(posedge clk);
         #1;
         out_ready = 1'b0;
         chk("bp_drain_out_valid", {31'd0, out_valid}, 32'd0);
         chk("bp_drain_in_ready", {31'd0, in_ready}, 32'd1);
         chk("bp_fp_kept", fp_out, 32'h42C80000);
         repeat (8) @(posedge clk);
         #1;
         chk("bp_no_ghost_output", {31'd0, out_valid}, 32'd0);
      end

      // Asynchronous reset in the middle of normalization.
      @(negedge clk);
      int_in = 32'hFFFFFFFF; is_signed = 1'b1; rm = 3'b000; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("mid_reset_out_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_reset_in_ready", {31'd0, in_ready}, 32'd1);
      chk("mid_reset_fp_out", fp_out, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      chk("mid_reset_no_output", {31'd0, out_valid}, 32'd0);
      run_op(32'h00000064, 1'b1, 3'b000, res, rnx, lat);
      chk("post_reset_fp", res, 32'h42C80000);
      chk("post_reset_nx", {31'd0, rnx}, 32'd0);
      chk("post_reset_latency", 32'(lat), 32'd6);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
